// File: rtl/fpu_pkg.sv
// Shared FPU constants: rounding modes, FP32 exponent constants, format defaults and the
// integer-to-float converter state encoding.
package fpu_pkg;

  localparam int unsigned DefaultFpSize       = 32;
  localparam int unsigned DefaultMantissaSize = 23;
  localparam int unsigned DefaultExponentSize = 8;
  localparam int unsigned SizeFpFmt           = 3;

  localparam logic [2:0] RmRne = 3'd0;
  localparam logic [2:0] RmRtz = 3'd1;
  localparam logic [2:0] RmRdn = 3'd2;
  localparam logic [2:0] RmRup = 3'd3;
  localparam logic [2:0] RmRmm = 3'd4;

  localparam int unsigned FpBias   = 127;
  // Exponent of a 32-bit magnitude whose MSB is set: bias + 31.
  localparam int unsigned NormBase = FpBias + 31;

  typedef enum logic [1:0] {
    StIdle,
    StNorm,
    StRound,
    StDone
  } i2f_state_e;

endpackage

// File: rtl/leading_zeroth_bit.sv
// Leading-zero counter with zero detect; count is 0 when the operand is zero.
module leading_zeroth_bit #(
  parameter int unsigned Bit_Length   = 32,
  parameter int unsigned Bit_Length_O = 5
) (
  input  logic [Bit_Length-1:0]   operand,
  output logic [Bit_Length_O-1:0] count,
  output logic                    is_zero
);

  // Highest set bit wins because it is visited last.
  always_comb begin
    count = '0;
    for (int i = 0; i < Bit_Length; i++) begin
      if (operand[i]) begin
        count = Bit_Length_O'(Bit_Length - 1 - i);
      end
    end
  end

  assign is_zero = ~|operand;

endmodule

// File: rtl/fpu_i2f_conv.sv
// Sequential int32/uint32 to FP32 converter (fcvt.s.w / fcvt.s.wu).
// Define FPU_I2F_UNSIGNED_EN to honour is_unsigned; otherwise every operand is signed.
module fpu_i2f_conv
  import fpu_pkg::*;
#(
  parameter int unsigned Fp_size       = DefaultFpSize,
  parameter int unsigned Mantissa_size = DefaultMantissaSize,
  parameter int unsigned Exponent_size = DefaultExponentSize
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [Fp_size-1:0]   in_data,
  input  logic                 is_unsigned,
  input  logic [SizeFpFmt-1:0] rm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Fp_size-1:0]   out_data,
  output logic                 out_nx
);

  localparam int unsigned LzW     = $clog2(Fp_size);
  localparam int unsigned GuardIx = Fp_size - 2 - Mantissa_size;

  i2f_state_e state_q, state_d;

  logic                     sign_q;
  logic [Fp_size-1:0]       mag_q;
  logic [SizeFpFmt-1:0]     rm_q;
  logic [Fp_size-1:0]       m_q;
  logic [Exponent_size-1:0] exp_q;
  logic                     zero_q;
  logic [Fp_size-1:0]       out_data_q;
  logic                     out_nx_q;

  logic                     sign_in;
  logic [Fp_size-1:0]       mag_in;
  logic [LzW-1:0]           lz;
  logic                     mag_zero;

`ifdef FPU_I2F_UNSIGNED_EN
  assign sign_in = in_data[Fp_size-1] & ~is_unsigned;
`else
  logic unused_is_unsigned;
  assign unused_is_unsigned = is_unsigned;
  assign sign_in = in_data[Fp_size-1];
`endif

  // 0x80000000 negates to itself, which is the correct magnitude.
  assign mag_in = sign_in ? (~in_data + 1'b1) : in_data;

  leading_zeroth_bit #(
    .Bit_Length  (Fp_size),
    .Bit_Length_O(LzW)
  ) u_lzc (
    .operand(mag_q),
    .count  (lz),
    .is_zero(mag_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = StNorm;
      StNorm:  state_d = StRound;
      StRound: state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  logic [Mantissa_size-1:0] frac;
  logic                     guard, sticky, lsb, round_up;
  logic [Mantissa_size:0]   frac_sum;
  logic [Exponent_size-1:0] exp_r;
  logic [Fp_size-1:0]       result;
  logic                     unused_m_msb;

  assign unused_m_msb = m_q[Fp_size-1];
  assign frac   = m_q[Fp_size-2 -: Mantissa_size];
  assign guard  = m_q[GuardIx];
  assign sticky = |m_q[GuardIx-1:0];
  assign lsb    = m_q[GuardIx+1];

  always_comb begin
    round_up = guard & (sticky | lsb);
    case (rm_q)
      RmRtz:   round_up = 1'b0;
      RmRdn:   round_up = sign_q & (guard | sticky);
      RmRup:   round_up = ~sign_q & (guard | sticky);
      RmRmm:   round_up = guard;
      default: round_up = guard & (sticky | lsb);
    endcase
  end

  // A fraction carry leaves frac_sum low bits at zero and bumps the exponent.
  assign frac_sum = {1'b0, frac} + (Mantissa_size + 1)'(round_up);
  assign exp_r    = exp_q + Exponent_size'(frac_sum[Mantissa_size]);
  assign result   = zero_q ? '0 : {sign_q, exp_r, frac_sum[Mantissa_size-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q     <= 1'b0;
      mag_q      <= '0;
      rm_q       <= '0;
      m_q        <= '0;
      exp_q      <= '0;
      zero_q     <= 1'b0;
      out_data_q <= '0;
      out_nx_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            sign_q <= sign_in;
            mag_q  <= mag_in;
            rm_q   <= rm;
          end
        end
        StNorm: begin
          m_q    <= mag_q << lz;
          exp_q  <= Exponent_size'(NormBase) - Exponent_size'(lz);
          zero_q <= mag_zero;
        end
        StRound: begin
          out_data_q <= result;
          out_nx_q   <= ~zero_q & (guard | sticky);
        end
        default: ;
      endcase
    end
  end

  assign out_data = out_data_q;
  assign out_nx   = out_nx_q;

endmodule

// File: tb/tb_fpu_i2f_conv.sv
// Directed bench for fpu_i2f_conv with an arithmetic reference model and a per-cycle checker.
module tb_fpu_i2f_conv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        is_unsigned;
  logic [2:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_nx;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_data_q[$];
  logic        exp_nx_q[$];

`ifdef FPU_I2F_UNSIGNED_EN
  localparam bit UnsEn = 1'b1;
`else
  localparam bit UnsEn = 1'b0;
`endif

  always #5 clk = ~clk;

  fpu_i2f_conv dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .is_unsigned(is_unsigned),
    .rm         (rm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_nx     (out_nx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: exact integer value, divide by 2^(e-23), round on the remainder.
  task automatic model(input logic [31:0] d, input logic u, input logic [2:0] r,
                       output logic [31:0] f, output logic nx);
    bit      neg;
    longint  mag, q, rem, half;
    int      e, sh;
    bit      up;
    neg = d[31] && !(u && UnsEn);
    mag = neg ? (64'h1_0000_0000 - longint'(d)) : longint'(d);
    f   = 32'h0;
    nx  = 1'b0;
    if (mag != 0) begin
      e = 0;
      for (int i = 0; i < 33; i++) if (mag >= (64'd1 << i)) e = i;
      if (e <= 23) begin
        q   = mag << (23 - e);
        rem = 0;
        half = 1;
      end else begin
        sh   = e - 23;
        q    = mag >> sh;
        rem  = mag - (q << sh);
        half = 64'd1 << (sh - 1);
      end
      case (r)
        3'd1:    up = 1'b0;
        3'd2:    up = neg && rem != 0;
        3'd3:    up = !neg && rem != 0;
        3'd4:    up = rem >= half;
        default: up = (rem > half) || (rem == half && q[0]);
      endcase
      if (up) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
      f  = {neg, 8'(e + 127), q[22:0]};
      nx = rem != 0;
    end
  endtask

  // Every cycle the output is presented it must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (exp_data_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'h0);
      end else begin
        check("out_data", out_data, exp_data_q[0]);
        check("out_nx", 32'(out_nx), 32'(exp_nx_q[0]));
        check("in_ready_in_done", 32'(in_ready), 32'h0);
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && exp_data_q.size() > 0) begin
      void'(exp_data_q.pop_front());
      void'(exp_nx_q.pop_front());
    end
  end

  task automatic run(input logic [31:0] d, input logic u, input logic [2:0] r,
                     input logic [31:0] lit_f, input logic lit_nx, input int hold);
    logic [31:0] f;
    logic        nx;
    model(d, u, r, f, nx);
    check("model_data", f, lit_f);
    check("model_nx", 32'(nx), 32'(lit_nx));
    exp_data_q.push_back(lit_f);
    exp_nx_q.push_back(lit_nx);
    check("in_ready_idle", 32'(in_ready), 32'h1);
    in_valid    = 1'b1;
    in_data     = d;
    is_unsigned = u;
    rm          = r;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_data     = $urandom;
    is_unsigned = ~u;
    rm          = 3'(~r);
    // Accept edge counts as edge one; valid must appear after the third.
    check("lat_edge1", 32'(out_valid), 32'h0);
    check("in_ready_norm", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    check("lat_edge2", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    check("lat_edge3", 32'(out_valid), 32'h1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("held_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_hs_valid", 32'(out_valid), 32'h0);
    check("post_hs_ready", 32'(in_ready), 32'h1);
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 32'h0;
    is_unsigned = 1'b0;
    rm          = 3'd0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_nx", 32'(out_nx), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(32'h0000_0001, 1'b0, 3'd0, 32'h3F80_0000, 1'b0, 0);
    run(32'h8000_0000, 1'b0, 3'd0, 32'hCF00_0000, 1'b0, 0);
    run(32'h0000_0000, 1'b0, 3'd3, 32'h0000_0000, 1'b0, 0);
    run(32'h7FFF_FFFF, 1'b0, 3'd0, 32'h4F00_0000, 1'b1, 0);
    run(32'h7FFF_FFFF, 1'b0, 3'd1, 32'h4EFF_FFFF, 1'b1, 0);
    run(32'h0100_0001, 1'b0, 3'd0, 32'h4B80_0000, 1'b1, 0);
    run(32'h0100_0001, 1'b0, 3'd3, 32'h4B80_0001, 1'b1, 0);
    run(32'h0100_0001, 1'b0, 3'd4, 32'h4B80_0001, 1'b1, 0);
    run(32'h0100_0001, 1'b0, 3'd6, 32'h4B80_0000, 1'b1, 0);
    run(32'hFEFF_FFFF, 1'b0, 3'd2, 32'hCB80_0001, 1'b1, 0);
    run(32'h0000_0003, 1'b0, 3'd1, 32'h4040_0000, 1'b0, 5);
`ifdef FPU_I2F_UNSIGNED_EN
    run(32'hFFFF_FFFF, 1'b1, 3'd0, 32'h4F80_0000, 1'b1, 2);
`else
    run(32'hFFFF_FFFF, 1'b1, 3'd0, 32'hBF80_0000, 1'b0, 2);
`endif
    run(32'hFFFF_FFFF, 1'b0, 3'd0, 32'hBF80_0000, 1'b0, 0);

    // Reset while in NORM: the conversion must vanish without an output.
    in_valid = 1'b1;
    in_data  = 32'h0000_1234;
    rm       = 3'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #2;
    check("midrst_in_ready", 32'(in_ready), 32'h1);
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_out_data", out_data, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("postrst_out_valid", 32'(out_valid), 32'h0);
      check("postrst_in_ready", 32'(in_ready), 32'h1);
    end

    run(32'h0000_000A, 1'b0, 3'd0, 32'h4120_0000, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
